// File: rtl/rf_pkg.sv
// Shared definitions for the integer register file bank.
package rf_pkg;

   // Clear-engine state: CLEAR zeroes storage after reset, RUN is normal operation.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } rf_state_e;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;

   // Architectural zero register: reads 0, never written, never busy.
   localparam int unsigned ZERO_REG  = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register with set/clear/flush priority.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [AW-1:0]    set_addr,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_addr,
   input  logic             flush,
   output logic [NREGS-1:0] busy
);

   logic [NREGS-1:0] busy_d;

   // Flush, then per-register clear, then set: the newest producer always wins.
   always_comb begin
      busy_d = busy;
      if (flush) begin
         busy_d = '0;
      end
      if (clr_en) begin
         busy_d[clr_addr] = 1'b0;
      end
      if (set_en && (set_addr != AW'(ZERO_REG))) begin
         busy_d[set_addr] = 1'b1;
      end
   end

   // Busy vector register.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_d;
      end
   end

endmodule

// File: rtl/regfile_bank.sv
// Multi-read, single-write register file with bypass, scoreboard and post-reset clear.
module regfile_bank
   import rf_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned NREGS  = NREGS_DEF,
   parameter int unsigned NREAD  = 2,
   parameter int unsigned BYPASS = 1,
   parameter int unsigned AW     = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREAD*AW-1:0]   rs_addr,
   output logic [NREAD*XLEN-1:0] rs_data,
   output logic [NREAD-1:0]      rs_busy,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [XLEN-1:0]       wr_data,
   input  logic                  iss_en,
   input  logic [AW-1:0]         iss_rd,
   input  logic                  flush,
   output logic                  ready
);

   rf_state_e        state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             run;
   logic             wr_ok;
   logic             iss_ok;
   logic             flush_ok;
   logic [NREGS-1:0] busy;
   logic [XLEN-1:0]  mem [NREGS];

   assign run      = (state_q == ST_RUN);
   assign ready    = run;
   assign wr_ok    = run && wr_en && (wr_addr != AW'(ZERO_REG));
   assign iss_ok   = run && iss_en;
   assign flush_ok = run && flush;

   // Clear engine next state: walk idx from 1 to NREGS-1, then enter RUN.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_CLEAR: begin
            if (idx_q == AW'(NREGS - 1)) begin
               state_d = ST_RUN;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_CLEAR;
            idx_d   = AW'(1);
         end
      endcase
   end

   // Clear engine state register; reset restarts the walk at entry 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         idx_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Storage: the clear engine owns the write port until RUN; entry 0 is never written.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!run) begin
            mem[idx_q] <= '0;
         end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
         end
      end
   end

   rf_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (iss_ok),
      .set_addr (iss_rd),
      .clr_en   (run && wr_en),
      .clr_addr (wr_addr),
      .flush    (flush_ok),
      .busy     (busy)
   );

   for (genvar i = 0; i < int'(NREAD); i++) begin : g_lane
      logic [AW-1:0]   addr;
      logic            wr_hit;
      logic            iss_hit;
      logic [XLEN-1:0] data;
      logic            bsy;

      assign addr = rs_addr[i*AW +: AW];

      // Read lane: zero while clearing or for r0, otherwise storage or forwarded write.
      always_comb begin
         wr_hit  = (BYPASS != 0) && wr_ok && (wr_addr == addr);
         iss_hit = iss_ok && (iss_rd == addr);
         data    = '0;
         bsy     = 1'b0;
         if (run && (addr != AW'(ZERO_REG))) begin
            data = wr_hit ? wr_data : mem[addr];
            bsy  = busy[addr] && !(wr_hit && !iss_hit);
         end
      end

      assign rs_data[i*XLEN +: XLEN] = data;
      assign rs_busy[i]              = bsy;
   end

endmodule

// File: doc/regfile_bank.md
# regfile_bank

Parametrised integer register file with N read ports, one write port, a write-to-read bypass, a pending-write scoreboard and a post-reset sequential clear engine. It sits in the decode stage of the pipeline core. Reads serve operand fetch. Writeback drives the write port. The issue logic uses the busy flags to stall on RAW hazards.

## Interface
Parameters:
- `XLEN`, 32: data width in bits.
- `NREGS`, 32: number of architectural registers; power of two, ≥ 4.
- `NREAD`, 2: number of read ports, 1 to 4.
- `BYPASS`, 1: when 1, a same-cycle write is forwarded to matching reads.
- `AW`, `$clog2(NREGS)`: address width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rs_addr`  in  `NREAD*AW`  read addresses; port i is bits `[i*AW +: AW]`.
- `rs_data`  out  `NREAD*XLEN`  read data, packed the same way as `rs_addr`.
- `rs_busy`  out  `NREAD`  port i's register has a pending write.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  `AW`  write address.
- `wr_data`  in  `XLEN`  write data.
- `iss_en`  in  1  an instruction writing `iss_rd` is issued; sets the busy flag.
- `iss_rd`  in  `AW`  destination of the issued instruction.
- `flush`  in  1  clears all busy flags; storage is unaffected.
- `ready`  out  1  clear engine finished; the block accepts writes and issues.

## Operation
- Register 0 always reads 0. Writes to register 0 are dropped. Register 0 is never marked busy.
- FSM states:
  - CLEAR: reset state. A pointer `idx` is loaded with 1 while `rst`=1. On each edge with `rst`=0, the block writes 0 to entry `idx`. When `idx`=`NREGS`-1 the FSM moves to RUN; otherwise `idx` is incremented.
  - RUN: normal operation. The only exit is `rst`.
- While in CLEAR:
  - `ready`=0.
  - Every `rs_data` lane reads 0.
  - `wr_en`, `iss_en` and `flush` are ignored.
- Reads are combinational from `rs_addr`. With `BYPASS`=1, if `wr_en`=1 and `wr_addr`=`rs_addr[i]`≠0, lane i returns `wr_data`. With `BYPASS`=0, lane i returns the old value.
- Scoreboard: one busy bit per register.
  - `iss_en` sets `busy[iss_rd]`.
  - `wr_en` clears `busy[wr_addr]`.
  - If both target the same register in the same cycle, the set wins, because the newer producer is still outstanding.
  - `flush` clears all bits. If `flush` and `iss_en` occur in the same cycle, the set of `iss_rd` still wins.
- `rs_busy[i]` = `busy[rs_addr[i]]`. With `BYPASS`=1 it is masked to 0 when a write to that register occurs in the same cycle and no same-cycle issue targets it.
- Multiple read ports may address the same register; all return identical data.

## Timing
- Reset values:
  - `ready`=0.
  - `rs_data`=0 on all lanes.
  - `rs_busy`=0.
  - All busy bits 0.
  - FSM in CLEAR with `idx`=1.
- Clear latency: `ready` rises after the (`NREGS`-1)-th rising edge with `rst`=0. For `NREGS`=32, that is 31 cycles.
- If `rst` is asserted mid-clear or in RUN, the block returns to CLEAR with `idx`=1 on that edge and the clear restarts.
- Write latency: data is stored on the edge that samples `wr_en`. The bypass makes it visible in the same cycle; without bypass it is visible from the next cycle.
- `iss_en` is reflected on `rs_busy` from the next cycle.
- No other output has register latency.

## Structure
- The shared package `rf_pkg` holds:
  - the FSM state enum (CLEAR, RUN);
  - default `XLEN` and `NREGS`;
  - the zero-register index constant.
- One sub-module is natural: `rf_scoreboard`, which holds the busy vector and the set/clear/flush priority logic. It is instantiated once.
- Storage, bypass muxes and the clear FSM live in the top module.

## Test plan
- Reset then clear: pulse `rst` for 2 cycles. Check `ready`=0 for 31 cycles, then 1. Check every register then reads 0.
- Write/read with bypass: in one cycle drive `wr_en`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF and `rs_addr[0]`=5. Expect `rs_data[0]`=0xDEADBEEF in that cycle. With `BYPASS`=0, expect the old value 0 in that cycle and 0xDEADBEEF in the next.
- Zero register: write 0x12345678 to register 0 and issue `iss_rd`=0. Expect reads of register 0 to return 0 and `rs_busy` to stay 0.
- Scoreboard priority:
  - Issue to register 7, then read it: expect `rs_busy`=1.
  - Issue and write register 7 in the same cycle: expect busy to remain 1.
  - Write register 7 alone: expect `rs_busy`=0 in that same cycle (bypass) and after.
- Flush: set busy on registers 3, 4 and 9, then pulse `flush` together with `iss_en` to register 4. Expect only `busy[4]`=1 afterwards.
- Reset mid-clear: assert `rst` at `idx`=10 after writing register 20 earlier. Expect `ready` to rise 31 cycles after the release, and register 20 to read 0.
